// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM stage: control bundle, default widths and the payload layout.
package ex_mem_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int CTRL_W         = 4;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   typedef struct packed {
      mem_ctrl_t                   ctrl;
      logic [DEF_DATA_W-1:0]       alu_result;
      logic [DEF_DATA_W-1:0]       store_data;
      logic [DEF_REG_ADDR_W-1:0]   write_reg;
   } ex_mem_payload_t;

   // Flattened payload width for arbitrary DATA_W / REG_ADDR_W (same field order as ex_mem_payload_t).
   function automatic int payload_w(input int data_w, input int reg_addr_w);
      return CTRL_W + 2 * data_w + reg_addr_w;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Main entry M drives the outputs; skid entry S catches one beat while M is stalled.
module pipe_skid_buf #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data
);

   logic                 r_m_valid;
   logic                 r_s_valid;
   logic                 r_in_ready;
   logic [PAYLOAD_W-1:0] r_m_data;
   logic [PAYLOAD_W-1:0] r_s_data;

   logic w_accept;
   logic w_drain;
   logic w_m_open;

   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = r_m_valid & out_ready;
   assign w_m_open = ~r_m_valid | w_drain;

   // r_in_ready mirrors "S empty" as its own flop so out_ready never reaches in_ready combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid  <= 1'b0;
         r_s_valid  <= 1'b0;
         r_in_ready <= 1'b1;
         r_m_data   <= '0;
         r_s_data   <= '0;
      end else if (flush) begin
         r_m_valid  <= 1'b0;
         r_s_valid  <= 1'b0;
         r_in_ready <= 1'b1;
      end else if (w_m_open) begin
         if (r_s_valid) begin
            r_m_valid  <= 1'b1;
            r_m_data   <= r_s_data;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
         end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
         end else begin
            r_m_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_s_valid  <= 1'b1;
         r_s_data   <= in_data;
         r_in_ready <= 1'b0;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_m_valid;
   assign out_data  = r_m_data;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready handshake, flush and skid buffering.
// Optional macro STALL_CNT_EN adds the saturating stall_cycles counter port.
module ex_mem_pipe
   import ex_mem_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef STALL_CNT_EN
   ,
   parameter int CNT_W      = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic                  in_mem_read,
   input  logic                  in_mem_write,
   input  logic                  in_mem_to_reg,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_store_data,
   input  logic [REG_ADDR_W-1:0] in_write_reg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_reg_write,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_mem_to_reg,
   output logic [DATA_W-1:0]     out_address,
   output logic [DATA_W-1:0]     out_store_data,
   output logic [REG_ADDR_W-1:0] out_write_reg
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles
`endif
);

   localparam int PAYLOAD_W = payload_w(DATA_W, REG_ADDR_W);

   mem_ctrl_t              w_in_ctrl;
   mem_ctrl_t              w_out_ctrl;
   logic [PAYLOAD_W-1:0]   w_in_payload;
   logic [PAYLOAD_W-1:0]   w_out_payload;
   logic                   w_out_valid;

   assign w_in_ctrl.reg_write  = in_reg_write;
   assign w_in_ctrl.mem_read   = in_mem_read;
   assign w_in_ctrl.mem_write  = in_mem_write;
   assign w_in_ctrl.mem_to_reg = in_mem_to_reg;

   assign w_in_payload = {w_in_ctrl, in_alu_result, in_store_data, in_write_reg};

   pipe_skid_buf #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_in_payload),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .out_data  (w_out_payload)
   );

   assign {w_out_ctrl, out_address, out_store_data, out_write_reg} = w_out_payload;

   // Bubbles must never write memory or the register file, whatever stale payload M holds.
   assign out_valid      = w_out_valid;
   assign out_reg_write  = w_out_ctrl.reg_write  & w_out_valid;
   assign out_mem_read   = w_out_ctrl.mem_read   & w_out_valid;
   assign out_mem_write  = w_out_ctrl.mem_write  & w_out_valid;
   assign out_mem_to_reg = w_out_ctrl.mem_to_reg & w_out_valid;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating; flush deliberately leaves it alone so stalls across squashes still accumulate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_ready && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX→MEM pipeline stage register with valid/ready handshake, synchronous flush and a 2-entry skid buffer.
- Sits between the execute stage (ALU result, store data, destination register, MEM/WB control) and the data-memory stage.
- Replaces the free-running stage register so the pipeline can stall (cache miss, multi-cycle op) and squash (branch/exception) without losing or duplicating instructions.

Parameters:
- DATA_W, 32, width of ALU result / memory address and store data.
- REG_ADDR_W, 5, width of destination register number.
- CNT_W, 32, width of stall counter (used only with STALL_CNT_EN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held and incoming entries.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; registered, equals "skid entry empty".
- in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg  in  1 each  control bits.
- in_alu_result  in  DATA_W  ALU result / memory address.
- in_store_data  in  DATA_W  store data.
- in_write_reg  in  REG_ADDR_W  destination register number.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage consumes the entry this cycle.
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  control bits ANDed with out_valid.
- out_address  out  DATA_W  registered in_alu_result.
- out_store_data  out  DATA_W  registered in_store_data.
- out_write_reg  out  REG_ADDR_W  registered in_write_reg.
- stall_cycles  out  CNT_W  present only with STALL_CNT_EN.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit.
- Reset (async, rst=1): M.valid=0, S.valid=0, all payload 0, so every out_* =0 and in_ready=1 after release.
- Transfer rules:
  - accept = in_valid & in_ready.
  - drain = M.valid & out_ready.
- M update, taken when M is empty or draining:
  - If S.valid: M<=S, S.valid<=0.
  - Else if accept: M<=input.
  - Else: M.valid<=0.
- S update: if M is full and not draining while accept, S<=input. In_ready=1 guarantees S is free.
- If M is empty or draining, S is empty, and accept: the input goes directly to M. Latency is 1 cycle with no stall.
- Throughput: 1 instruction/cycle while out_ready=1. Strict in-order delivery; no loss, no duplication.
- in_ready is a flop (no combinational path from out_ready); it deasserts the cycle after S fills.
- Flush: clears M.valid and S.valid next edge; the same-cycle input is dropped. Flush has priority over accept and drain. Payload need not be cleared.
- Control gating: out_mem_write and out_reg_write are never 1 while out_valid=0, so bubbles cannot write memory or the register file.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset mid-stall: all entries discarded immediately; no output glitch beyond async clear.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: stall_cycles increments each cycle out_valid=1 and out_ready=0. It saturates at all-ones, is cleared by rst, and is not cleared by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (ex_mem_pkg):
  - DATA_W/REG_ADDR_W defaults.
  - Packed struct mem_ctrl_t {reg_write, mem_read, mem_write, mem_to_reg}.
  - Packed struct ex_mem_payload_t {mem_ctrl_t ctrl, alu_result, store_data, write_reg}.
- One sub-module, pipe_skid_buf: generic 2-entry valid/ready skid buffer over a PAYLOAD_W-bit vector with flush.
- ex_mem_pipe packs/unpacks the payload, applies control gating, and holds the optional counter.

Test Plan:
- Reset: rst=1 mid-stream with M and S full → out_valid=0, out_mem_write=0, in_ready=1 immediately after release.
- Streaming: out_ready=1, feed alu_result 0x100,0x104,0x108 on consecutive cycles → out_address shows each one cycle later, back-to-back, out_valid=1 for exactly 3 cycles.
- Backpressure: out_ready=0 while feeding 0xA0,0xA4 → in_ready=0 after the second is accepted. Outputs hold 0xA0. Raise out_ready → 0xA0 then 0xA4 delivered, no drop.
- Flush: S and M full, assert flush with in_valid=1 (0xDEAD, mem_write=1) → next cycle out_valid=0, out_mem_write=0, in_ready=1, and 0xDEAD never appears.
- Gating: in_valid=0 with in_reg_write=1, in_write_reg=5 → out_reg_write stays 0.
- STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles → stall_cycles=7. Flush leaves it 7; rst clears it to 0.
